// File: rtl/iob_fp_f2i.sv
// Pipelined IEEE-754 float to signed integer converter, round to nearest even.
// Three register stages (unpack, align, round/saturate); one operand per cycle.
module iob_fp_f2i #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned INT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] op_i,
    output logic              done_o,
    output logic [INT_W-1:0]  res_o,
    output logic              overflow_o,
    output logic              invalid_o,
    output logic              inexact_o
);

    localparam int unsigned MAN_W  = DATA_W - EXP_W;
    localparam int unsigned FRAC_W = MAN_W - 1;
    localparam int unsigned BIAS   = 2 ** (EXP_W - 1) - 1;
    localparam int signed   MSB_POS = int'(MAN_W) - 1;
    localparam int signed   INT_LIM = int'(INT_W);

    localparam logic [INT_W:0]   NEG_LIM = (INT_W + 1)'(1) << (INT_W - 1);
    localparam logic [INT_W:0]   POS_LIM = NEG_LIM - (INT_W + 1)'(1);
    localparam logic [INT_W-1:0] SAT_POS = {1'b0, {(INT_W - 1){1'b1}}};
    localparam logic [INT_W-1:0] SAT_NEG = {1'b1, {(INT_W - 1){1'b0}}};

    // ---------------- stage 1: unpack ----------------
    logic              s1_valid;
    logic              s1_sign;
    logic [EXP_W-1:0]  s1_exp;
    logic [MAN_W-1:0]  s1_man;
    logic              s1_nan;
    logic              s1_inf;

    logic              in_sign_c;
    logic [EXP_W-1:0]  in_exp_c;
    logic [FRAC_W-1:0] in_frac_c;

    always_comb begin
        in_sign_c = op_i[DATA_W-1];
        in_exp_c  = op_i[DATA_W-2 -: EXP_W];
        in_frac_c = op_i[FRAC_W-1:0];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_exp   <= '0;
            s1_man   <= '0;
            s1_nan   <= 1'b0;
            s1_inf   <= 1'b0;
        end else begin
            s1_valid <= start_i;
            if (start_i) begin
                s1_sign <= in_sign_c;
                s1_exp  <= in_exp_c;
                s1_man  <= {(in_exp_c != '0), in_frac_c};
                s1_nan  <= (&in_exp_c) & (|in_frac_c);
                s1_inf  <= (&in_exp_c) & ~(|in_frac_c);
            end
        end
    end

    // ---------------- stage 2: align ----------------
    logic                s2_valid;
    logic                s2_sign;
    logic                s2_nan;
    logic                s2_inf;
    logic                s2_pre_ovf;
    logic [INT_W-1:0]    s2_mag;
    logic                s2_guard;
    logic                s2_sticky;

    logic signed [31:0]  unb_exp;
    logic [31:0]         rsh;
    logic [2*MAN_W-1:0]  ext;
    logic [INT_W-1:0]    mag_c;
    logic                guard_c;
    logic                sticky_c;
    logic                pre_ovf_c;

    // Right shifts push the dropped bits into the low half of ext so guard
    // and sticky fall out of fixed bit positions; out-of-range skips shifting.
    always_comb begin
        unb_exp   = 32'(s1_exp) - 32'(BIAS);
        rsh       = '0;
        ext       = '0;
        mag_c     = '0;
        guard_c   = 1'b0;
        sticky_c  = 1'b0;
        pre_ovf_c = 1'b0;
        if (unb_exp >= INT_LIM) begin
            pre_ovf_c = 1'b1;
        end else if (unb_exp < 0) begin
            guard_c  = (unb_exp == -1) & s1_man[MAN_W-1];
            sticky_c = (unb_exp == -1) ? (|s1_man[MAN_W-2:0]) : (|s1_man);
        end else if (unb_exp < MSB_POS) begin
            rsh      = 32'(MSB_POS - unb_exp);
            ext      = {s1_man, MAN_W'(0)} >> rsh;
            mag_c    = INT_W'(ext[2*MAN_W-1:MAN_W]);
            guard_c  = ext[MAN_W-1];
            sticky_c = |ext[MAN_W-2:0];
        end else begin
            mag_c = INT_W'(s1_man) << 32'(unb_exp - MSB_POS);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s2_valid   <= 1'b0;
            s2_sign    <= 1'b0;
            s2_nan     <= 1'b0;
            s2_inf     <= 1'b0;
            s2_pre_ovf <= 1'b0;
            s2_mag     <= '0;
            s2_guard   <= 1'b0;
            s2_sticky  <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sign    <= s1_sign;
                s2_nan     <= s1_nan;
                s2_inf     <= s1_inf;
                s2_pre_ovf <= pre_ovf_c;
                s2_mag     <= mag_c;
                s2_guard   <= guard_c;
                s2_sticky  <= sticky_c;
            end
        end
    end

    // ---------------- stage 3: round, sign, saturate ----------------
    logic             inc_c;
    logic [INT_W:0]   mag_r_c;
    logic [INT_W-1:0] mag_lo_c;
    logic [INT_W-1:0] signed_c;
    logic             ovf_c;

    always_comb begin
        inc_c    = s2_guard & (s2_sticky | s2_mag[0]);
        mag_r_c  = {1'b0, s2_mag} + (INT_W + 1)'(inc_c);
        mag_lo_c = mag_r_c[INT_W-1:0];
        signed_c = s2_sign ? (~mag_lo_c + INT_W'(1)) : mag_lo_c;
        ovf_c    = s2_inf | s2_pre_ovf | (mag_r_c > (s2_sign ? NEG_LIM : POS_LIM));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            done_o     <= 1'b0;
            res_o      <= '0;
            overflow_o <= 1'b0;
            invalid_o  <= 1'b0;
            inexact_o  <= 1'b0;
        end else begin
            done_o <= s2_valid;
            if (s2_valid) begin
                if (s2_nan) begin
                    res_o      <= SAT_POS;
                    overflow_o <= 1'b0;
                    invalid_o  <= 1'b1;
                    inexact_o  <= 1'b0;
                end else if (ovf_c) begin
                    res_o      <= s2_sign ? SAT_NEG : SAT_POS;
                    overflow_o <= 1'b1;
                    invalid_o  <= 1'b0;
                    inexact_o  <= 1'b0;
                end else begin
                    res_o      <= signed_c;
                    overflow_o <= 1'b0;
                    invalid_o  <= 1'b0;
                    inexact_o  <= s2_guard | s2_sticky;
                end
            end
        end
    end

endmodule

// File: tb/tb_iob_fp_f2i.sv
// Self-checking bench for iob_fp_f2i: hand-derived vectors, queue scoreboard,
// latency/throughput pattern checks and an asynchronous mid-flight reset.
module tb_iob_fp_f2i;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] op;
    logic        done;
    logic [31:0] res;
    logic        ovf, inv, inx;

    iob_fp_f2i #(.DATA_W(32), .EXP_W(8), .INT_W(32)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op),
        .done_o(done), .res_o(res), .overflow_o(ovf), .invalid_o(inv), .inexact_o(inx)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int n_pass = 0;
    int n_total = 0;

    // {operand, expected result, overflow, invalid, inexact}
    typedef struct packed {
        logic [31:0] op;
        logic [31:0] res;
        logic [2:0]  flg;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [2:0]  flg;
        int          edge_n;
    } exp_t;

    localparam int NV = 25;
    vec_t vecs [NV] = '{
        {32'h3F800000, 32'h00000001, 3'b000},   // 1.0
        {32'hC2F60000, 32'hFFFFFF85, 3'b000},   // -123.0
        {32'h40200000, 32'h00000002, 3'b001},   // 2.5
        {32'h40600000, 32'h00000004, 3'b001},   // 3.5
        {32'hBFC00000, 32'hFFFFFFFE, 3'b001},   // -1.5
        {32'h3ECCCCCD, 32'h00000000, 3'b001},   // 0.4
        {32'h3F000000, 32'h00000000, 3'b001},   // 0.5
        {32'h4F000000, 32'h7FFFFFFF, 3'b100},   // 2^31
        {32'hCF000000, 32'h80000000, 3'b000},   // -2^31
        {32'h7F800000, 32'h7FFFFFFF, 3'b100},   // +Inf
        {32'hFF800000, 32'h80000000, 3'b100},   // -Inf
        {32'h4EFFFFFF, 32'h7FFFFF80, 3'b000},   // largest float below 2^31
        {32'h7FC00000, 32'h7FFFFFFF, 3'b010},   // qNaN
        {32'h80000000, 32'h00000000, 3'b000},   // -0.0
        {32'h00000001, 32'h00000000, 3'b001},   // smallest subnormal
        {32'h41200000, 32'h0000000A, 3'b000},   // 10.0
        {32'hC0200000, 32'hFFFFFFFE, 3'b001},   // -2.5
        {32'h3FC00000, 32'h00000002, 3'b001},   // 1.5
        {32'hCF000001, 32'h80000000, 3'b100},   // just below -2^31
        {32'h4F800000, 32'h7FFFFFFF, 3'b100},   // 2^32
        {32'h3F7FFFFF, 32'h00000001, 3'b001},   // just below 1.0
        {32'hFFC00000, 32'h7FFFFFFF, 3'b010},   // negative NaN
        {32'h00000000, 32'h00000000, 3'b000},   // +0.0
        {32'h4B000001, 32'h00800001, 3'b000},   // 2^23+1, no shift
        {32'h4AFFFFFF, 32'h00800000, 3'b001}    // 8388607.5 rounds up
    };

    exp_t sb[$];

    task automatic drive_op(input logic [31:0] v);
        start = 1'b1;
        op    = v;
    endtask

    task automatic issue(input int k);
        exp_t e;
        e.res    = vecs[k].res;
        e.flg    = vecs[k].flg;
        e.edge_n = edge_cnt;
        sb.push_back(e);
        drive_op(vecs[k].op);
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        op    = '0;
        repeat (3) @(negedge clk);
        n_total++;
        if ({done, res, ovf, inv, inx} !== 36'h0)
            $display("FAIL reset_state: got done=%b res=%h flags=%b%b%b want all zero",
                     done, res, ovf, inv, inx);
        else n_pass++;
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_exact_latency();
        for (int t = 0; t < 2; t++) begin
            drive_op(vecs[t].op);
            for (int c = 1; c <= 3; c++) begin
                @(negedge clk);
                start = 1'b0;
                n_total++;
                if (done !== (c == 3))
                    $display("FAIL latency_%0d_cycle%0d: got done=%b want %b", t, c, done, (c == 3));
                else n_pass++;
            end
            n_total++;
            if ({res, ovf, inv, inx} !== {vecs[t].res, vecs[t].flg})
                $display("FAIL exact_%0d: got res=%h flags=%b%b%b want res=%h flags=%b",
                         t, res, ovf, inv, inx, vecs[t].res, vecs[t].flg);
            else n_pass++;
            @(negedge clk);
            n_total++;
            if (done !== 1'b0 || res !== vecs[t].res)
                $display("FAIL hold_%0d: got done=%b res=%h want done=0 res=%h",
                         t, done, res, vecs[t].res);
            else n_pass++;
        end
    endtask

    task automatic test_vectors();
        exp_t e;
        for (int c = 0; c < NV + 8; c++) begin
            @(negedge clk);
            if (done) begin
                n_total++;
                if (sb.size() == 0) begin
                    $display("FAIL vec_extra_done: got done=1 want no pending result");
                end else begin
                    n_pass++;
                    e = sb.pop_front();
                    n_total++;
                    if ({res, ovf, inv, inx} !== {e.res, e.flg})
                        $display("FAIL vec_value: got res=%h flags=%b%b%b want res=%h flags=%b",
                                 res, ovf, inv, inx, e.res, e.flg);
                    else n_pass++;
                    n_total++;
                    if (edge_cnt - e.edge_n != 3)
                        $display("FAIL vec_latency: got %0d want 3", edge_cnt - e.edge_n);
                    else n_pass++;
                end
            end
            if (c < NV) issue(c);
            else start = 1'b0;
        end
        n_total++;
        if (sb.size() != 0) $display("FAIL vec_missing: got %0d pending want 0", sb.size());
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int   pat [22] = '{1,1,1,1,1,1,1,1, 0,1,1,0,0,1,0,1, 0,0,0,0,0,0};
        int   k = 0;
        logic want_done;
        exp_t e;
        for (int c = 0; c < 22; c++) begin
            @(negedge clk);
            want_done = (c >= 3) ? (pat[c-3] != 0) : 1'b0;
            n_total++;
            if (done !== want_done)
                $display("FAIL b2b_done_c%0d: got %b want %b", c, done, want_done);
            else n_pass++;
            if (done && sb.size() != 0) begin
                e = sb.pop_front();
                n_total++;
                if ({res, ovf, inv, inx} !== {e.res, e.flg})
                    $display("FAIL b2b_value_c%0d: got res=%h flags=%b%b%b want res=%h flags=%b",
                             c, res, ovf, inv, inx, e.res, e.flg);
                else n_pass++;
            end
            if (pat[c] != 0) begin
                issue((k * 3 + 1) % NV);
                k++;
            end else begin
                start = 1'b0;
            end
        end
        n_total++;
        if (sb.size() != 0) $display("FAIL b2b_missing: got %0d pending want 0", sb.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        drive_op(vecs[1].op);
        @(negedge clk) drive_op(vecs[15].op);
        @(negedge clk) drive_op(vecs[2].op);
        @(negedge clk) start = 1'b0;
        n_total++;
        if (done !== 1'b1 || res !== vecs[1].res)
            $display("FAIL pre_reset: got done=%b res=%h want done=1 res=%h", done, res, vecs[1].res);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_total++;
        if ({done, res, ovf, inv, inx} !== 36'h0)
            $display("FAIL async_reset: got done=%b res=%h flags=%b%b%b want all zero",
                     done, res, ovf, inv, inx);
        else n_pass++;
        sb.delete();
        @(negedge clk) rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_total++;
            if (done !== 1'b0) $display("FAIL flushed_done_c%0d: got %b want 0", c, done);
            else n_pass++;
        end
        drive_op(vecs[3].op);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            start = 1'b0;
            n_total++;
            if (done !== (c == 3))
                $display("FAIL post_reset_latency_c%0d: got %b want %b", c, done, (c == 3));
            else n_pass++;
        end
        n_total++;
        if ({res, ovf, inv, inx} !== {vecs[3].res, vecs[3].flg})
            $display("FAIL post_reset_value: got res=%h flags=%b%b%b want res=%h flags=%b",
                     res, ovf, inv, inx, vecs[3].res, vecs[3].flg);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_exact_latency();
        test_vectors();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish before 200000");
        $fatal(1);
    end

endmodule
